instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Reverse of the instruction field decoder: accepts MIPS instruction fields plus a format select, and packs them into 32-bit instruction words.
- Streams the packed words into instruction memory through its write port, one word per accepted beat, at sequential addresses.
- Used by the program-load path (test harness or boot loader) ahead of the fetch stage.

Parameters:
- ADDR_W, 10, word-address width of the instruction-memory write port.
- DEPTH, 1024, number of writable words; must satisfy DEPTH <= 2^ADDR_W.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a load session; honoured in IDLE or DONE only.
- in_valid  in  1  field beat valid.
- in_ready  out  1  block can accept a beat.
- in_last  in  1  beat is the final word of the session.
- in_fmt  in  2  0=R, 1=I, 2=J, 3=illegal.
- in_opcode  in  6  instr[31:26].
- in_rs  in  5  R/I: instr[25:21].
- in_rt  in  5  R/I: instr[20:16].
- in_rd  in  5  R: instr[15:11].
- in_shamt  in  5  R: instr[10:6].
- in_funct  in  6  R: instr[5:0].
- in_imm  in  16  I: instr[15:0].
- in_target  in  26  J: instr[25:0].
- mem_we  out  1  instruction-memory write enable.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  32  packed instruction.
- busy  out  1  state is LOAD.
- done  out  1  one-cycle pulse on session end.
- overflow  out  1  sticky; session hit DEPTH before in_last.
- fmt_err  out  1  sticky; an illegal-format beat was accepted.
- word_count  out  ADDR_W+1  words written this session.

Behaviour:
- Reset (async, rst=0): state IDLE. All of the following are 0: in_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow, fmt_err, word_count.
- States: IDLE, LOAD, DONE.
- IDLE/DONE with start=1: next state LOAD. On that edge, mem_addr<=BASE_ADDR and word_count, overflow and fmt_err clear.
- start is ignored while in LOAD.
- in_ready=1 only in LOAD, and only while word_count < DEPTH.
- A beat is accepted when in_valid && in_ready.
- Accepted beat, latency 1: the next cycle has mem_we=1 and mem_wdata=packed word at the current mem_addr. mem_addr and word_count increment after that write cycle.
- Back-to-back beats are sustained at one word per cycle.
- Packing:
  - R: {opcode, rs, rt, rd, shamt, funct}.
  - I: {opcode, rs, rt, imm}.
  - J: {opcode, target}.
  - Unused fields are ignored.
- Illegal fmt=3: the word is written as 32'h0000_0000 (nop) and fmt_err sets. The session continues.
- Accepted beat with in_last=1: the write completes, then LOAD->DONE, with done=1 for exactly one cycle.
- The write that makes word_count reach DEPTH without in_last: overflow sets, LOAD->DONE, done pulses, in_ready drops.
- in_last coinciding with the DEPTH-th write: treat as normal completion, overflow=0.
- mem_addr does not wrap: after DEPTH words it holds BASE_ADDR+DEPTH-1.
- DONE holds word_count, overflow and fmt_err until the next start.
- Reset mid-session: abort immediately, no further writes. Memory contents already written are untouched.

Optional Feature:
- Macro INSTR_ENC_CHECKSUM_EN.
- Defined: adds output checksum [31:0], the running XOR of every written mem_wdata. It clears on start and on reset, and is valid when done pulses.
- Undefined: the port and its logic are absent.

Decomposition:
- Shared package holds:
  - format codes FMT_R=2'd0, FMT_I=2'd1, FMT_J=2'd2, FMT_ILL=2'd3;
  - state encoding;
  - NOP_WORD=32'h0;
  - field bit-position constants shared with the decoder.
- Sub-module instr_pack: purely combinational fmt+fields -> 32-bit word, plus an illegal flag.
- The top level holds the FSM, the output register, and the address and count logic.

Test Plan:
- start; one R beat (op=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20, last=1) -> next cycle mem_we=1, addr=0, wdata=32'h00221820; done pulses; word_count=1.
- Three back-to-back beats: I (op=0x08, rs=1, rt=1, imm=0x0005), J (op=0x02, target=0x0000010), then I with last -> wdata=32'h20210005, then 32'h08000010, then the third word, at addrs 0,1,2 on consecutive cycles; done pulses after the third.
- DEPTH=4 and 6 beats with no last -> 4 writes; overflow=1; in_ready=0 from the 4th write on; done pulses once; mem_addr holds 3.
- fmt=3 beat mid-stream -> nop written at that address; fmt_err=1; the following beats still written.
- rst asserted low while in LOAD with in_valid high -> all outputs 0 in the same cycle; no mem_we after release until a new start.
- Checksum build: writes 32'hFFFF0000 then 32'h0000FFFF -> checksum=32'hFFFFFFFF at done.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// Shared encodings for the instruction encoder/loader and the matching field decoder.
package instr_encoder_loader_pkg;

   localparam logic [1:0] FMT_R   = 2'd0;
   localparam logic [1:0] FMT_I   = 2'd1;
   localparam logic [1:0] FMT_J   = 2'd2;
   localparam logic [1:0] FMT_ILL = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   // LSB positions of each instruction field
   localparam int unsigned OPCODE_LSB = 26;
   localparam int unsigned RS_LSB     = 21;
   localparam int unsigned RT_LSB     = 16;
   localparam int unsigned RD_LSB     = 11;
   localparam int unsigned SHAMT_LSB  = 6;
   localparam int unsigned FUNCT_LSB  = 0;
   localparam int unsigned IMM_LSB    = 0;
   localparam int unsigned TARGET_LSB = 0;

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// instr_pack: combinational packing of MIPS instruction fields into a 32-bit word.
module instr_pack
   import instr_encoder_loader_pkg::*;
(
   input  logic [1:0]  fmt,
   input  logic [5:0]  opcode,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [5:0]  funct,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        illegal
);

   always_comb begin
      word    = NOP_WORD;
      illegal = 1'b0;
      case (fmt)
         FMT_R: word = (32'(opcode) << OPCODE_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB)
                     | (32'(rd) << RD_LSB) | (32'(shamt) << SHAMT_LSB) | (32'(funct) << FUNCT_LSB);
         FMT_I: word = (32'(opcode) << OPCODE_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB)
                     | (32'(imm) << IMM_LSB);
         FMT_J: word = (32'(opcode) << OPCODE_LSB) | (32'(target) << TARGET_LSB);
         default: begin
            word    = NOP_WORD;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs instruction field beats and streams them into instruction memory at sequential addresses.
// Optional running-XOR checksum output enabled by INSTR_ENC_CHECKSUM_EN.
module instr_encoder_loader
   import instr_encoder_loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [1:0]        in_fmt,
   input  logic [5:0]        in_opcode,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [5:0]        in_funct,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              fmt_err,
   output logic [ADDR_W:0]   word_count
`ifdef INSTR_ENC_CHECKSUM_EN
   ,output logic [31:0]      checksum
`endif
);

   localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE_W  = ADDR_W'(BASE_ADDR);

   state_t          state, state_nxt;
   logic [31:0]     packed_word;
   logic            pack_ill;
   logic            accept;
   logic            start_ok;
   logic            wr_last;
   logic            last_seen;
   logic [ADDR_W:0] acc_cnt;
   logic            wr_at_depth;
   logic            final_wr;

   instr_pack u_pack (
      .fmt     (in_fmt),
      .opcode  (in_opcode),
      .rs      (in_rs),
      .rt      (in_rt),
      .rd      (in_rd),
      .shamt   (in_shamt),
      .funct   (in_funct),
      .imm     (in_imm),
      .target  (in_target),
      .word    (packed_word),
      .illegal (pack_ill)
   );

   // acc_cnt/last_seen run one cycle ahead of word_count so back-to-back beats never overshoot DEPTH
   assign busy        = (state == ST_LOAD);
   assign in_ready    = busy && !last_seen && (acc_cnt < DEPTH_W);
   assign accept      = in_valid && in_ready;
   assign start_ok    = start && (state != ST_LOAD);
   assign wr_at_depth = ((word_count + (ADDR_W+1)'(1)) == DEPTH_W);
   assign final_wr    = mem_we && (wr_last || wr_at_depth);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: if (start) state_nxt = ST_LOAD;
         ST_LOAD:          if (final_wr) state_nxt = ST_DONE;
         default:          state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         done       <= 1'b0;
         overflow   <= 1'b0;
         fmt_err    <= 1'b0;
         word_count <= '0;
         wr_last    <= 1'b0;
         last_seen  <= 1'b0;
         acc_cnt    <= '0;
      end else begin
         mem_we <= accept;
         done   <= 1'b0;
         if (start_ok) begin
            mem_addr   <= BASE_W;
            word_count <= '0;
            overflow   <= 1'b0;
            fmt_err    <= 1'b0;
            acc_cnt    <= '0;
            last_seen  <= 1'b0;
            wr_last    <= 1'b0;
         end
         if (accept) begin
            mem_wdata <= packed_word;
            wr_last   <= in_last;
            acc_cnt   <= acc_cnt + (ADDR_W+1)'(1);
            if (in_last)  last_seen <= 1'b1;
            if (pack_ill) fmt_err   <= 1'b1;
         end
         if (mem_we) begin
            word_count <= word_count + (ADDR_W+1)'(1);
            if (!wr_at_depth) mem_addr <= mem_addr + ADDR_W'(1);
            if (final_wr) begin
               done <= 1'b1;
               if (!wr_last) overflow <= 1'b1;
            end
         end
      end
   end

`ifdef INSTR_ENC_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          checksum <= '0;
      else if (start_ok) checksum <= '0;
      else if (mem_we)   checksum <= checksum ^ mem_wdata;
   end
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed and randomized load sessions against a behavioural model.
module tb_instr_encoder_loader;

   localparam int unsigned ADDR_W    = 4;
   localparam int unsigned DEPTH     = 4;
   localparam int unsigned BASE_ADDR = 0;
   localparam int          NB        = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_last = 1'b0;
   logic [1:0]        in_fmt = '0;
   logic [5:0]        in_opcode = '0;
   logic [4:0]        in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
   logic [5:0]        in_funct = '0;
   logic [15:0]       in_imm = '0;
   logic [25:0]       in_target = '0;
   logic              in_ready, mem_we, busy, done, overflow, fmt_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [ADDR_W:0]   word_count;
`ifdef INSTR_ENC_CHECKSUM_EN
   logic [31:0]       checksum;
`endif

   always #5 clk = ~clk;

   instr_encoder_loader #(
      .ADDR_W    (ADDR_W),
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE_ADDR)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_last    (in_last),
      .in_fmt     (in_fmt),
      .in_opcode  (in_opcode),
      .in_rs      (in_rs),
      .in_rt      (in_rt),
      .in_rd      (in_rd),
      .in_shamt   (in_shamt),
      .in_funct   (in_funct),
      .in_imm     (in_imm),
      .in_target  (in_target),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .fmt_err    (fmt_err),
      .word_count (word_count)
`ifdef INSTR_ENC_CHECKSUM_EN
      ,.checksum  (checksum)
`endif
   );

   int n_cmp = 0;
   int n_fail = 0;

   logic [1:0]  b_fmt [NB];
   logic [5:0]  b_op  [NB];
   logic [4:0]  b_rs  [NB], b_rt [NB], b_rd [NB], b_sh [NB];
   logic [5:0]  b_fn  [NB];
   logic [15:0] b_imm [NB];
   logic [25:0] b_tgt [NB];
   logic [31:0] first_wd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %08h want %08h", tag, obs, exp);
      end
   endtask

   task automatic set_beat(input int i, input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                           input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt);
      b_fmt[i] = f;  b_op[i] = op;  b_rs[i] = rs;  b_rt[i] = rt;  b_rd[i] = rd;
      b_sh[i]  = sh; b_fn[i] = fn;  b_imm[i] = imm; b_tgt[i] = tgt;
   endtask

   task automatic rand_beat(input int i);
      set_beat(i, 2'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom));
   endtask

   task automatic drive_beat(input int i);
      in_fmt = b_fmt[i]; in_opcode = b_op[i]; in_rs = b_rs[i]; in_rt = b_rt[i]; in_rd = b_rd[i];
      in_shamt = b_sh[i]; in_funct = b_fn[i]; in_imm = b_imm[i]; in_target = b_tgt[i];
   endtask

   // Reference encoding: each field weighted by 2**(field LSB)
   function automatic logic [31:0] ref_word(input int i);
      logic [31:0] w;
      case (b_fmt[i])
         2'd0: w = 32'(b_op[i]) * 32'h0400_0000 + 32'(b_rs[i]) * 32'h0020_0000 + 32'(b_rt[i]) * 32'h0001_0000
                 + 32'(b_rd[i]) * 32'h0000_0800 + 32'(b_sh[i]) * 32'h0000_0040 + 32'(b_fn[i]);
         2'd1: w = 32'(b_op[i]) * 32'h0400_0000 + 32'(b_rs[i]) * 32'h0020_0000 + 32'(b_rt[i]) * 32'h0001_0000
                 + 32'(b_imm[i]);
         2'd2: w = 32'(b_op[i]) * 32'h0400_0000 + 32'(b_tgt[i]);
         default: w = 32'h0;
      endcase
      return w;
   endfunction

   task automatic run_session(input string tag, input int n, input int last_idx, input bit gaps);
      int          acc, beat, cyc;
      bit          ended, got_done, done_next, want_ready, take, last_acc, fe;
      logic [31:0] ck, w;
      acc = 0; beat = 0; cyc = 0;
      ended = 0; got_done = 0; done_next = 0; last_acc = 0; fe = 0;
      ck = '0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, ":busy_start"}, 32'(busy), 32'd1);
      chk({tag, ":wc_start"}, 32'(word_count), 32'd0);
      chk({tag, ":ovf_start"}, 32'(overflow), 32'd0);
      chk({tag, ":fe_start"}, 32'(fmt_err), 32'd0);
      while (!got_done && cyc < 100) begin
         want_ready = !ended && (acc < int'(DEPTH));
         chk({tag, ":in_ready"}, 32'(in_ready), 32'(want_ready));
         in_valid = 1'b0;
         in_last  = 1'b0;
         if (gaps) start = 1'($urandom);
         if (beat < n && (!gaps || $urandom_range(0, 3) != 0)) begin
            in_valid = 1'b1;
            drive_beat(beat);
            in_last = (beat == last_idx);
         end
         take = in_valid && want_ready;
         @(posedge clk); #1;
         cyc++;
         chk({tag, ":done"}, 32'(done), 32'(done_next));
         if (done_next) got_done = 1;
         done_next = 0;
         chk({tag, ":mem_we"}, 32'(mem_we), 32'(take));
         if (take) begin
            w = ref_word(beat);
            chk({tag, ":addr"}, 32'(mem_addr), 32'(BASE_ADDR + acc));
            chk({tag, ":wdata"}, mem_wdata, w);
            if (acc == 0) first_wd = mem_wdata;
            ck = ck ^ w;
            if (b_fmt[beat] == 2'd3) fe = 1;
            if (beat == last_idx) last_acc = 1;
            acc++;
            beat++;
            if (last_acc || acc == int'(DEPTH)) begin
               ended = 1;
               done_next = 1;
            end
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      start    = 1'b0;
      if (!got_done) begin
         n_cmp++;
         n_fail++;
         $error("FAIL %s:timeout got no done pulse want done within 100 cycles", tag);
      end
      chk({tag, ":wc_end"}, 32'(word_count), 32'(acc));
      chk({tag, ":ovf_end"}, 32'(overflow), 32'(!last_acc && acc == int'(DEPTH)));
      chk({tag, ":fe_end"}, 32'(fmt_err), 32'(fe));
      chk({tag, ":addr_end"}, 32'(mem_addr), 32'(BASE_ADDR + ((acc < int'(DEPTH)) ? acc : int'(DEPTH) - 1)));
      chk({tag, ":busy_end"}, 32'(busy), 32'd0);
`ifdef INSTR_ENC_CHECKSUM_EN
      chk({tag, ":checksum"}, checksum, ck);
`endif
      @(posedge clk); #1;
      chk({tag, ":done_once"}, 32'(done), 32'd0);
      chk({tag, ":we_idle"}, 32'(mem_we), 32'd0);
      chk({tag, ":wc_hold"}, 32'(word_count), 32'(acc));
   endtask

   initial begin
      int n, li;
      #12;
      chk("rst:in_ready", 32'(in_ready), 32'd0);
      chk("rst:mem_we", 32'(mem_we), 32'd0);
      chk("rst:mem_addr", 32'(mem_addr), 32'd0);
      chk("rst:mem_wdata", mem_wdata, 32'd0);
      chk("rst:busy", 32'(busy), 32'd0);
      chk("rst:done", 32'(done), 32'd0);
      chk("rst:word_count", 32'(word_count), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // single R beat with last
      set_beat(0, 2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
      run_session("r_single", 1, 0, 0);
      chk("r_single:const", first_wd, 32'h0022_1820);

      // I, J, I(last) back to back
      set_beat(0, 2'd1, 6'h08, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0);
      set_beat(1, 2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h000_0010);
      set_beat(2, 2'd1, 6'h23, 5'd4, 5'd9, 5'd0, 5'd0, 6'h0, 16'h8001, 26'h0);
      run_session("ijl", 3, 2, 0);
      chk("ijl:const", first_wd, 32'h2021_0005);

      // overflow: six beats, no last
      for (int i = 0; i < 6; i++) rand_beat(i);
      run_session("ovf", 6, -1, 0);

      // last coincides with the DEPTH-th write
      for (int i = 0; i < 4; i++) rand_beat(i);
      run_session("last_at_depth", 4, 3, 0);

      // illegal format mid-stream
      set_beat(0, 2'd0, 6'h00, 5'd5, 5'd6, 5'd7, 5'd2, 6'h21, 16'h0, 26'h0);
      set_beat(1, 2'd3, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FF_FFFF);
      set_beat(2, 2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h123_4567);
      run_session("illegal", 3, 2, 0);

      // checksum pair
      set_beat(0, 2'd1, 6'h3F, 5'd31, 5'd31, 5'd0, 5'd0, 6'h0, 16'h0000, 26'h0);
      set_beat(1, 2'd1, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0);
      run_session("cksum", 2, 1, 0);
`ifdef INSTR_ENC_CHECKSUM_EN
      chk("cksum:const", checksum, 32'hFFFF_FFFF);
`endif

      // randomized sessions with valid gaps and start noise during LOAD
      for (int s = 0; s < 8; s++) begin
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) rand_beat(i);
         if (n >= int'(DEPTH) && $urandom_range(0, 1) == 1) li = -1;
         else li = $urandom_range(0, n - 1);
         run_session("rand", n, li, 1);
      end

      // reset in the middle of a session
      for (int i = 0; i < 4; i++) rand_beat(i);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 2; c++) begin
         in_valid = 1'b1;
         drive_beat(c);
         @(posedge clk); #1;
      end
      #2 rst = 1'b0;
      #1;
      chk("midrst:in_ready", 32'(in_ready), 32'd0);
      chk("midrst:mem_we", 32'(mem_we), 32'd0);
      chk("midrst:mem_addr", 32'(mem_addr), 32'd0);
      chk("midrst:mem_wdata", mem_wdata, 32'd0);
      chk("midrst:busy", 32'(busy), 32'd0);
      chk("midrst:word_count", 32'(word_count), 32'd0);
      chk("midrst:fmt_err", 32'(fmt_err), 32'd0);
`ifdef INSTR_ENC_CHECKSUM_EN
      chk("midrst:checksum", checksum, 32'd0);
`endif
      #3 rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("postrst:mem_we", 32'(mem_we), 32'd0);
         chk("postrst:in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;

      // recovery after reset
      set_beat(0, 2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h000_0040);
      run_session("recover", 1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
